// File: rtl/local_bus_slave_regfile.sv
// Local-bus slave register file with a fixed-latency read pipeline.
// Optional slv_err error strobe is enabled by LOCAL_BUS_SLV_ERR_EN.
module local_bus_slave_regfile #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int RD_LATENCY = 1,
  parameter logic [255:0] RO_MASK = '0,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = 'hDEAD_BEEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic addr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic rw_direction,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic rvalid,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status
`ifdef LOCAL_BUS_SLV_ERR_EN
  ,
  output logic slv_err
`endif
);

  localparam int SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH:0] NREG =
    (ADDR_WIDTH + 1)'(NUM_REGS);

  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] idx_full;
  logic [IW-1:0] idx;
  logic in_range;
  logic wr_hit;
  logic rd_req;
  logic [NUM_REGS*DATA_WIDTH-1:0] rd_src;
  logic [DATA_WIDTH-1:0] rd_val;

  logic [RD_LATENCY-1:0] vld;
  logic [DATA_WIDTH-1:0] dat [RD_LATENCY];

  assign off = addr - BASE_ADDR;
  assign idx_full = off >> SHIFT;
  assign idx = idx_full[IW-1:0];
  assign in_range = (addr >= BASE_ADDR) &&
                    ({1'b0, idx_full} < NREG);
  assign wr_hit = addr_en & rw_direction & in_range;
  assign rd_req = addr_en & ~rw_direction;

  assign rd_val = in_range
    ? rd_src[32'(idx) * DATA_WIDTH +: DATA_WIDTH]
    : ERR_DATA;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic [DATA_WIDTH-1:0] q;
    logic [DATA_WIDTH-1:0] hw;

    assign hw = hw_status[i*DATA_WIDTH +: DATA_WIDTH];
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = q;

    if (RO_MASK[i]) begin : g_ro
      assign rd_src[i*DATA_WIDTH +: DATA_WIDTH] = hw;

      // Read-only entry mirrors the hardware status value
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) q <= '0;
        else          q <= hw;
      end
    end else begin : g_rw
      logic unused_hw;
      assign unused_hw = ^hw;
      assign rd_src[i*DATA_WIDTH +: DATA_WIDTH] = q;

      // Writable entry updates on a decoded bus write
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          q <= '0;
        else if (wr_hit && idx == IW'(i))
          q <= wdata;
      end
    end
  end

  // Read pipeline: valid bit plus data per stage, data held when idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld <= '0;
      for (int k = 0; k < RD_LATENCY; k++) dat[k] <= '0;
    end else begin
      vld[0] <= rd_req;
      if (rd_req) dat[0] <= rd_val;
      for (int k = 1; k < RD_LATENCY; k++) begin
        vld[k] <= vld[k-1];
        if (vld[k-1]) dat[k] <= dat[k-1];
      end
    end
  end

  assign rvalid = vld[RD_LATENCY-1];
  assign rdata = dat[RD_LATENCY-1];

`ifdef LOCAL_BUS_SLV_ERR_EN
  logic is_ro;
  logic wr_err;
  logic [RD_LATENCY-1:0] rd_err;

  assign is_ro = RO_MASK[idx];

  // Error flags: one-cycle write error, read error rides the pipeline
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_err <= 1'b0;
      rd_err <= '0;
    end else begin
      wr_err <= addr_en & rw_direction & (~in_range | is_ro);
      rd_err[0] <= rd_req & ~in_range;
      for (int k = 1; k < RD_LATENCY; k++)
        rd_err[k] <= rd_err[k-1];
    end
  end

  assign slv_err = wr_err |
                   (vld[RD_LATENCY-1] & rd_err[RD_LATENCY-1]);
`endif

  logic unused_wr;
  assign unused_wr = wr_hit & RO_MASK[255];

endmodule

// File: tb/tb_local_bus_slave_regfile.sv
// Bench for local_bus_slave_regfile: directed vector table,
// hand sequences for reset/flush, randomized traffic vs. a model.
module tb_local_bus_slave_regfile;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int N = 16;
  localparam int L = 3;
  localparam logic [15:0] BASE = 16'h0100;
  localparam logic [31:0] ERRV = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset_n;
  logic addr_en;
  logic [AW-1:0] addr;
  logic rw_direction;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic rvalid;
  logic [N*DW-1:0] reg_q;
  logic [N*DW-1:0] hw;
`ifdef LOCAL_BUS_SLV_ERR_EN
  logic slv_err;
`endif

  always #5 clk = ~clk;

  local_bus_slave_regfile #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_REGS(N),
    .BASE_ADDR(BASE),
    .RD_LATENCY(L),
    .RO_MASK(256'h2),
    .ERR_DATA(ERRV)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .addr_en(addr_en),
    .addr(addr),
    .rw_direction(rw_direction),
    .wdata(wdata),
    .rdata(rdata),
    .rvalid(rvalid),
    .reg_q(reg_q),
    .hw_status(hw)
`ifdef LOCAL_BUS_SLV_ERR_EN
    ,
    .slv_err(slv_err)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] m [N];
  logic [31:0] exp_rdata;
  bit pv [int];
  logic [31:0] pd [int];
  bit pe [int];
  bit we [int];

  function automatic bit ro(input int i);
    return i == 1;
  endfunction

  function automatic int decode(input logic [15:0] a);
    int i;
    if (a < BASE) return -1;
    i = (int'(a) - int'(BASE)) / 4;
    return (i < N) ? i : -1;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d got %h expected %h",
               name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) m[i] = '0;
    pv.delete();
    pd.delete();
    pe.delete();
    we.delete();
    exp_rdata = '0;
  endtask

  task automatic cycle(input bit en, input bit rw,
                       input logic [15:0] a,
                       input logic [31:0] wd);
    int i;
    bit ev;
    addr_en = en;
    rw_direction = rw;
    addr = a;
    wdata = wd;
    @(posedge clk);
    cyc++;
    if (en) begin
      i = decode(a);
      if (rw) begin
        if (i >= 0 && !ro(i)) m[i] = wd;
        else we[cyc] = 1'b1;
      end else begin
        pv[cyc+L-1] = 1'b1;
        pe[cyc+L-1] = (i < 0);
        if (i < 0) pd[cyc+L-1] = ERRV;
        else if (ro(i)) pd[cyc+L-1] = hw[i*32 +: 32];
        else pd[cyc+L-1] = m[i];
      end
    end
    #1;
    ev = pv.exists(cyc);
    if (ev) exp_rdata = pd[cyc];
    chk("rvalid", 32'(rvalid), 32'(ev));
    chk("rdata", rdata, exp_rdata);
    for (int k = 0; k < N; k++)
      if (!ro(k))
        chk($sformatf("reg_q[%0d]", k), reg_q[k*32 +: 32], m[k]);
`ifdef LOCAL_BUS_SLV_ERR_EN
    chk("slv_err", 32'(slv_err),
        32'((ev && pe[cyc]) || we.exists(cyc)));
`endif
    @(negedge clk);
    addr_en = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    addr_en = 1'b0;
    #1;
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    for (int k = 0; k < N; k++)
      chk($sformatf("rst_reg_q[%0d]", k), reg_q[k*32 +: 32], 32'd0);
    model_clear();
    repeat (2) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit en;
    bit rw;
    logic [15:0] a;
    logic [31:0] wd;
    logic [31:0] hw1;
    bit ev;
    logic [31:0] ed;
  } vec_t;

  initial begin
    vec_t tbl [$];
    int rv_seen;

    reset_n = 1'b0;
    addr_en = 1'b0;
    rw_direction = 1'b0;
    addr = '0;
    wdata = '0;
    for (int i = 0; i < N; i++) hw[i*32 +: 32] = $urandom;
    hw[63:32] = 32'd2;
    model_clear();

    tbl.push_back('{1, 1, 16'h0108, 32'hA5A5_0001, 2, 0, 0});
    tbl.push_back('{1, 0, 16'h0108, 0, 2, 0, 0});
    tbl.push_back('{0, 0, 16'h0, 0, 2, 0, 0});
    tbl.push_back('{0, 0, 16'h0, 0, 2, 1, 32'hA5A5_0001});
    tbl.push_back('{1, 1, 16'h0100, 1, 2, 0, 32'hA5A5_0001});
    tbl.push_back('{1, 1, 16'h0104, 2, 2, 0, 32'hA5A5_0001});
    tbl.push_back('{1, 1, 16'h0108, 3, 2, 0, 32'hA5A5_0001});
    tbl.push_back('{1, 1, 16'h010C, 4, 2, 0, 32'hA5A5_0001});
    tbl.push_back('{1, 0, 16'h0100, 0, 2, 0, 32'hA5A5_0001});
    tbl.push_back('{1, 0, 16'h0104, 0, 2, 0, 32'hA5A5_0001});
    tbl.push_back('{1, 0, 16'h0108, 0, 2, 1, 1});
    tbl.push_back('{1, 0, 16'h010C, 0, 2, 1, 2});
    tbl.push_back('{0, 0, 16'h0, 0, 2, 1, 3});
    tbl.push_back('{0, 0, 16'h0, 0, 2, 1, 4});
    tbl.push_back('{0, 0, 16'h0, 0, 2, 0, 4});
    tbl.push_back('{1, 1, 16'h0114, 32'h55, 2, 0, 4});
    tbl.push_back('{1, 0, 16'h0114, 0, 2, 0, 4});
    tbl.push_back('{0, 0, 16'h0, 0, 2, 0, 4});
    tbl.push_back('{0, 0, 16'h0, 0, 2, 1, 32'h55});
    tbl.push_back('{1, 1, 16'h0104, 32'h1234, 32'hCAFE, 0, 32'h55});
    tbl.push_back('{1, 0, 16'h0104, 0, 32'hCAFE, 0, 32'h55});
    tbl.push_back('{0, 0, 16'h0, 0, 32'hCAFE, 0, 32'h55});
    tbl.push_back('{0, 0, 16'h0, 0, 32'hCAFE, 1, 32'hCAFE});
    tbl.push_back('{1, 0, 16'h0140, 0, 32'hCAFE, 0, 32'hCAFE});
    tbl.push_back('{0, 0, 16'h0, 0, 32'hCAFE, 0, 32'hCAFE});
    tbl.push_back('{0, 0, 16'h0, 0, 32'hCAFE, 1, ERRV});
    tbl.push_back('{1, 0, 16'h00FC, 0, 32'hCAFE, 0, ERRV});
    tbl.push_back('{0, 0, 16'h0, 0, 32'hCAFE, 0, ERRV});
    tbl.push_back('{0, 0, 16'h0, 0, 32'hCAFE, 1, ERRV});
    tbl.push_back('{1, 0, 16'h010B, 0, 32'hCAFE, 0, ERRV});
    tbl.push_back('{0, 0, 16'h0, 0, 32'hCAFE, 0, ERRV});
    tbl.push_back('{0, 0, 16'h0, 0, 32'hCAFE, 1, 3});

    @(negedge clk);
    do_reset();

    foreach (tbl[r]) begin
      hw[63:32] = tbl[r].hw1;
      cycle(tbl[r].en, tbl[r].rw, tbl[r].a, tbl[r].wd);
      chk($sformatf("tbl%0d_rvalid", r), 32'(rvalid), 32'(tbl[r].ev));
      chk($sformatf("tbl%0d_rdata", r), rdata, tbl[r].ed);
    end
    chk("t2_reg_q2", reg_q[2*32 +: 32], 32'd3);

    cycle(1, 0, 16'h0108, 0);
    cycle(0, 0, 16'h0, 0);
    do_reset();
    rv_seen = 0;
    for (int c = 0; c < 8; c++) begin
      cycle(0, 0, 16'h0, 0);
      if (rvalid) rv_seen++;
    end
    chk("flush_no_rvalid", 32'(rv_seen), 32'd0);
    chk("flush_reg2", reg_q[2*32 +: 32], 32'd0);

    for (int c = 0; c < 600; c++) begin
      if (c % 23 == 0)
        for (int i = 0; i < N; i++) hw[i*32 +: 32] = $urandom;
      if (c == 300) do_reset();
      cycle($urandom_range(0, 3) != 0, 1'($urandom % 2),
            16'h00F0 + 16'($urandom_range(0, 'h60)), $urandom);
    end
    repeat (L + 1) cycle(0, 0, 16'h0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
